// File: rtl/adc_driver.sv
// ADC capture/accumulate engine: sums triggered 128-bit ADC beats per beat/lane
// and streams the 32-bit sums to the CPU once averaging is complete.

module adc_driver_lane #(
  parameter int MEM_DEPTH = 16,
  parameter int IDX_W     = 4,
  parameter int SMP_W     = 16,
  parameter int ACC_W     = 32
) (
  input  logic             pl_clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             acc_en,
  input  logic [IDX_W-1:0] acc_idx,
  input  logic [SMP_W-1:0] sample,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [ACC_W-1:0] rd_data
);

  logic [MEM_DEPTH-1:0][ACC_W-1:0] mem;

  // Plain two's-complement add: overflow wraps by design.
  always_ff @(posedge pl_clk) begin
    if (rst || clr) mem <= '0;
    else if (acc_en) mem[acc_idx] <= mem[acc_idx] + {{(ACC_W-SMP_W){sample[SMP_W-1]}}, sample};
  end

  assign rd_data = mem[rd_idx];

endmodule

module adc_driver #(
  parameter int MEM_DEPTH = 16,
  parameter int CFG_W     = 16
) (
  input  logic         pl_clk,
  input  logic         rst,
  input  logic [15:0]  gpio_ctrl,
  input  logic [127:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [31:0]  m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  input  logic         select_in
);

  localparam int NUM_LANES = 8;
  localparam int SMP_W     = 16;
  localparam int ACC_W     = 32;
  localparam int LANE_W    = $clog2(NUM_LANES);
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W     = $clog2(MEM_DEPTH + 1);
  localparam int WRD_W     = CNT_W + LANE_W;

  typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;

  logic [15:0]      gpio_s1, gpio_s2;
  logic [3:0]       gpio_d, rise;
  logic [CFG_W-1:0] run_cycles, shift_val;
  logic [CNT_W-1:0] eff_cfg;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d, eff_q, eff_d;
  logic [WRD_W-1:0] word_q, word_d, word_last;
  logic             avail_q, avail_d;
  logic             tready_q;
  logic             acc_en, acc_clr, out_vld;

  logic [NUM_LANES-1:0][ACC_W-1:0] lane_rd;
  logic [IDX_W-1:0]                rd_beat;
  logic [LANE_W-1:0]               rd_lane;

  // Control lines are asynchronous to pl_clk; edges are taken after the synchronizer.
  always_ff @(posedge pl_clk) begin
    if (rst) begin
      gpio_s1 <= '0;
      gpio_s2 <= '0;
      gpio_d  <= '0;
    end else begin
      gpio_s1 <= gpio_ctrl;
      gpio_s2 <= gpio_s1;
      gpio_d  <= gpio_s2[3:0];
    end
  end

  assign rise = gpio_s2[3:0] & ~gpio_d;

  // Serial config: LSB first, shifted in from the top.
  always_ff @(posedge pl_clk) begin
    if (rst) begin
      run_cycles <= '0;
      shift_val  <= '0;
    end else if (select_in) begin
      if (rise[2]) run_cycles <= {gpio_s2[1], run_cycles[CFG_W-1:1]};
      if (rise[3]) shift_val  <= {gpio_s2[1], shift_val[CFG_W-1:1]};
    end
  end

  assign eff_cfg   = (run_cycles > CFG_W'(MEM_DEPTH)) ? CNT_W'(MEM_DEPTH) : CNT_W'(run_cycles);
  assign word_last = {eff_q, {LANE_W{1'b0}}} - 1'b1;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    eff_d   = eff_q;
    word_d  = word_q;
    avail_d = avail_q;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    out_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (avail_q && shift_val == '0) begin
          state_d = READOUT;
          word_d  = '0;
        end else if (rise[0] && eff_cfg != '0) begin
          // A zero beat count leaves the existing sums and their length untouched.
          state_d = CAPTURE;
          eff_d   = eff_cfg;
          beat_d  = '0;
        end
      end
      CAPTURE: begin
        if (s_axis_tvalid) begin
          acc_en = 1'b1;
          if (beat_q == eff_q - 1'b1) begin
            state_d = IDLE;
            avail_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      READOUT: begin
        out_vld = 1'b1;
        if (m_axis_tready) begin
          if (word_q == word_last) begin
            state_d = IDLE;
            avail_d = 1'b0;
            acc_clr = 1'b1;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pl_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      eff_q    <= '0;
      word_q   <= '0;
      avail_q  <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      eff_q    <= eff_d;
      word_q   <= word_d;
      avail_q  <= avail_d;
      tready_q <= 1'b1;
    end
  end

  assign rd_beat = word_q[IDX_W+LANE_W-1:LANE_W];
  assign rd_lane = word_q[LANE_W-1:0];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    adc_driver_lane #(
      .MEM_DEPTH(MEM_DEPTH),
      .IDX_W    (IDX_W),
      .SMP_W    (SMP_W),
      .ACC_W    (ACC_W)
    ) u_lane (
      .pl_clk (pl_clk),
      .rst    (rst),
      .clr    (acc_clr),
      .acc_en (acc_en),
      .acc_idx(beat_q[IDX_W-1:0]),
      .sample (s_axis_tdata[l*SMP_W +: SMP_W]),
      .rd_idx (rd_beat),
      .rd_data(lane_rd[l])
    );
  end

  // Read index only moves on a handshake, so tdata is stable under back-pressure.
  assign m_axis_tdata  = out_vld ? lane_rd[rd_lane] : '0;
  assign m_axis_tvalid = out_vld;
  assign s_axis_tready = tready_q;

endmodule

// File: tb/tb_adc_driver.sv
// Directed/randomized bench for adc_driver against a per-beat/lane sum model.

module tb_adc_driver;

  localparam int DEPTH = 16;
  localparam int CFGW  = 16;
  localparam logic [127:0] AVG_DATA = {16'h1000, 16'h2000, 16'h3000, 16'h4000,
                                       16'h5000, 16'h6000, 16'h7000, 16'h8000};

  logic         pl_clk = 1'b0;
  logic         rst;
  logic [15:0]  gpio_ctrl;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid, s_axis_tready;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready;
  logic         select_in;

  adc_driver #(.MEM_DEPTH(DEPTH), .CFG_W(CFGW)) dut (
    .pl_clk       (pl_clk),
    .rst          (rst),
    .gpio_ctrl    (gpio_ctrl),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .select_in    (select_in)
  );

  always #5 pl_clk = ~pl_clk;

  int n_pass = 0, n_fail = 0, n_total = 0;

  // Reference model: plain integer sums per beat/lane plus config shadows.
  int  m_acc [DEPTH][8];
  int  m_run, m_shift, m_eff_cap;
  logic [31:0] got [$];

  task automatic cyc(input int n);
    repeat (n) @(negedge pl_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < DEPTH; b++)
      for (int s = 0; s < 8; s++) m_acc[b][s] = 0;
    m_eff_cap = 0;
  endtask

  task automatic write_cfg(input int which, input logic [15:0] val, input bit sel);
    select_in = sel;
    for (int i = 0; i < CFGW; i++) begin
      gpio_ctrl[1] = val[i];
      cyc(3);
      gpio_ctrl[which] = 1'b1;
      cyc(3);
      gpio_ctrl[which] = 1'b0;
      cyc(3);
    end
    select_in = 1'b1;
    if (sel) begin
      if (which == 2) m_run = int'(val);
      else            m_shift = int'(val);
    end
  endtask

  task automatic trigger_capture(input int nsend, input bit fixed, input bit retrig);
    logic [127:0] d;
    logic [15:0]  smp;
    int eff;
    eff = (m_run > DEPTH) ? DEPTH : m_run;
    gpio_ctrl[0] = 1'b1;
    cyc(4);
    gpio_ctrl[0] = 1'b0;
    cyc(1);
    if (retrig) gpio_ctrl[0] = 1'b1;
    for (int k = 0; k < nsend; k++) begin
      s_axis_tvalid = 1'b0;
      cyc($urandom_range(0, 2));
      if (fixed) d = AVG_DATA;
      else d = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      if (k < eff)
        for (int s = 0; s < 8; s++) begin
          smp = d[s*16 +: 16];
          m_acc[k][s] = m_acc[k][s] + int'($signed(smp));
        end
      cyc(1);
    end
    s_axis_tvalid = 1'b0;
    gpio_ctrl[0]  = 1'b0;
    cyc(4);
    if (eff > 0) m_eff_cap = eff;
  endtask

  task automatic readout(input bit rnd, input int stop_after);
    logic [31:0] exp_q [$];
    logic [31:0] held, td;
    logic tv;
    bit stalled, rdy;
    int budget, limit;
    got.delete();
    stalled = 1'b0;
    held = '0;
    for (int b = 0; b < m_eff_cap; b++)
      for (int s = 0; s < 8; s++) exp_q.push_back(m_acc[b][s]);
    limit  = (stop_after > 0) ? stop_after : exp_q.size();
    budget = 40 * limit + 200;
    while (got.size() < limit && budget > 0) begin
      tv = m_axis_tvalid;
      td = m_axis_tdata;
      if (stalled) begin
        check("stall_tvalid", {31'b0, tv}, 32'd1);
        check("stall_tdata", td, held);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axis_tready = rdy;
      if (tv && rdy) got.push_back(td);
      stalled = tv && !rdy;
      held = td;
      budget--;
      cyc(1);
    end
    m_axis_tready = 1'b0;
    check("word_count", got.size(), limit);
    if (stop_after == 0) begin
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
        check($sformatf("word%0d", i), got[i], exp_q[i]);
      watch_quiet(20, "tail_tvalid");
      model_clear();
    end
  endtask

  task automatic watch_quiet(input int n, input string tag);
    int cnt;
    cnt = 0;
    m_axis_tready = 1'b1;
    repeat (n) begin
      if (m_axis_tvalid) cnt++;
      cyc(1);
    end
    m_axis_tready = 1'b0;
    check(tag, cnt, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    gpio_ctrl = '0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    select_in = 1'b1;
    m_run = 0;
    m_shift = 0;
    model_clear();

    cyc(3);
    check("rst_m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("rst_m_tdata", m_axis_tdata, 32'd0);
    check("rst_s_tready", {31'b0, s_axis_tready}, 32'd0);
    rst = 1'b0;
    cyc(1);
    check("run_s_tready", {31'b0, s_axis_tready}, 32'd1);
    check("run_m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);

    // Averaging: four triggers of four identical beats, held off until shift_val=0.
    write_cfg(3, 16'd2, 1'b1);
    write_cfg(2, 16'd4, 1'b1);
    repeat (4) trigger_capture(4, 1'b1, 1'b0);
    watch_quiet(150, "holdoff_tvalid");
    write_cfg(3, 16'd0, 1'b1);
    readout(1'b0, 0);
    for (int b = 0; b < 4 && b * 8 + 7 < got.size(); b++) begin
      check($sformatf("avg_b%0d_lane0", b), got[b*8+0], 32'hFFFE0000);
      check($sformatf("avg_b%0d_lane1", b), got[b*8+1], 32'h0001C000);
      check($sformatf("avg_b%0d_lane7", b), got[b*8+7], 32'h00004000);
    end

    // Random data under random back-pressure, with extra beats past the count.
    write_cfg(2, 16'd6, 1'b1);
    trigger_capture(7, 1'b0, 1'b0);
    readout(1'b1, 0);

    // Config clocks with select_in=0 must not change anything; retrigger ignored.
    write_cfg(2, 16'hFFFF, 1'b0);
    write_cfg(3, 16'h0005, 1'b0);
    trigger_capture(6, 1'b0, 1'b1);
    readout(1'b1, 0);

    // Zero beat count: a trigger produces nothing.
    write_cfg(2, 16'd0, 1'b1);
    trigger_capture(3, 1'b0, 1'b0);
    watch_quiet(100, "zero_run_tvalid");

    // Beat count above depth clamps to MEM_DEPTH.
    write_cfg(2, 16'd40, 1'b1);
    trigger_capture(18, 1'b0, 1'b0);
    readout(1'b1, 0);

    // Reset after five words, then a fresh single capture.
    write_cfg(2, 16'd3, 1'b1);
    trigger_capture(3, 1'b0, 1'b0);
    readout(1'b0, 5);
    rst = 1'b1;
    cyc(1);
    check("midrst_m_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("midrst_m_tdata", m_axis_tdata, 32'd0);
    check("midrst_s_tready", {31'b0, s_axis_tready}, 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("postrst_s_tready", {31'b0, s_axis_tready}, 32'd1);
    m_run = 0;
    m_shift = 0;
    model_clear();
    write_cfg(2, 16'd3, 1'b1);
    trigger_capture(3, 1'b0, 1'b0);
    readout(1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adc_driver.md
ADC_DRIVER -- requirements
Module: adc_driver

Interface
REQ-001 The block SHALL have one clock, pl_clk, and a synchronous, active-high reset, rst, sampled on the pl_clk rising edge.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 16: the maximum number of 128-bit ADC beats captured per trigger.
REQ-003 The block SHALL have parameter CFG_W, default 16: the width of each serial config register.
REQ-004 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- pl_clk  in  1  clock
- rst  in  1  sync active-high reset
- gpio_ctrl  in  16  control lines: bit0 trigger, bit1 sdata, bit2 run_cycles_clk, bit3 shift_val_clk, bits15:4 ignored
- s_axis_tdata  in  128  eight signed 16-bit samples; bits[15:0] is sample 0, the earliest
- s_axis_tvalid  in  1  ADC beat valid
- s_axis_tready  out  1  ADC ready
- m_axis_tdata  out  32  accumulated sample word to the CPU
- m_axis_tvalid  out  1  output word valid
- m_axis_tready  in  1  CPU ready
- select_in  in  1  enables the serial config shift clocks

Function
REQ-005 All gpio_ctrl bits SHALL pass through a 2-flop synchronizer; edge detection SHALL use the synchronized values.
REQ-006 The run_cycles register (CFG_W bits) SHALL shift on each synchronized rising edge of bit2 while select_in=1, as reg <= {sdata, reg[CFG_W-1:1]}, so that data sent LSB first lands aligned.
REQ-007 The shift_val register SHALL behave as in REQ-006, using bit3 as its shift clock.
REQ-008 Config clock edges SHALL be ignored while select_in=0.
REQ-009 The effective beat count SHALL be min(run_cycles, MEM_DEPTH); a count of 0 SHALL mean a trigger captures nothing.
REQ-010 s_axis_tready SHALL be constant 1 outside reset; beats are never stalled.
REQ-011 The FSM SHALL have three states: IDLE, CAPTURE, READOUT.
REQ-012 In IDLE, a synchronized rising edge of bit0 SHALL move the FSM to CAPTURE with the beat index at 0.
REQ-013 Trigger edges SHALL be ignored in CAPTURE and READOUT.
REQ-014 In CAPTURE, each beat with s_axis_tvalid=1 SHALL update beat k, lane s as acc[k][s] += sign_extend32(sample s); beats with s_axis_tvalid=0 SHALL be skipped without advancing the index.
REQ-015 After the last effective beat, the FSM SHALL return to IDLE and set the data_avail flag.
REQ-016 Accumulators SHALL be 32-bit two's complement and wrap on overflow, with no saturation.
REQ-017 The FSM SHALL go IDLE -> READOUT only when shift_val==0 and data_avail=1; shift_val!=0 means averaging is in progress and readout is held off.
REQ-018 In READOUT, words SHALL be streamed in the order beat 0 lanes 0..7, then beat 1 lanes 0..7, and so on, for effective_beats*8 words; each word is the raw 32-bit sum.
REQ-019 Each output word SHALL advance only on m_axis_tvalid & m_axis_tready.
REQ-020 m_axis_tdata SHALL be held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 m_axis_tvalid SHALL be 1 only in READOUT.
REQ-022 Once started, a readout SHALL run to completion even if shift_val changes.
REQ-023 After the final word handshake, the block SHALL clear all accumulators and data_avail and return to IDLE.
REQ-024 Effective beat count and shift_val SHALL be sampled at trigger time and at readout start respectively; later config writes do not affect an operation in progress.

Reset
REQ-025 rst=1 SHALL force IDLE, clear both config registers, all accumulators, data_avail and the synchronizers, and drive m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0.
REQ-026 rst asserted mid-CAPTURE or mid-READOUT SHALL abort the operation and discard all partial data.
REQ-027 Outputs SHALL take their run values on the first pl_clk edge after rst deasserts.

Verification
REQ-028 Bench SHALL cover the averaging case: run_cycles=4, shift_val=2, four trigger pulses with s_axis_tdata={1000,2000,3000,4000,5000,6000,7000,8000}h, then shift_val=0 and m_axis_tready=1 -> exactly 32 words; for every beat, lane0=FFFE0000h, lane1=0001C000h, lane7=00004000h; m_axis_tvalid then drops to 0.
REQ-029 Bench SHALL cover readout hold-off: shift_val=2 with data_avail=1 -> m_axis_tvalid stays 0 indefinitely.
REQ-030 Bench SHALL cover back-pressure: toggle m_axis_tready randomly during readout -> word sequence unchanged, no word lost or duplicated, tdata stable while stalled.
REQ-031 Bench SHALL cover bounds: run_cycles=0 -> trigger yields no words; run_cycles=40 -> MEM_DEPTH*8 = 128 words.
REQ-032 Bench SHALL cover config gating: shift clock pulses with select_in=0 -> registers unchanged; trigger during CAPTURE -> ignored, sums reflect one capture.
REQ-033 Bench SHALL cover reset mid-readout: assert rst after 5 words -> tvalid=0; a new single capture then reads back one trigger's sums, not accumulated with prior data.
